// File: rtl/seg_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : seg_scan_ctrl
// Brief    : Multiplexed 7-seg+dp scanner, double-buffered data, PWM
//            brightness. Define SEG_LZ_BLANK_EN for leading-zero blanking.
// Revision : 1.0 - initial release
// ============================================================================
module seg_scan_ctrl #(
  parameter int CLK_FREQ  = 50_000_000,
  parameter int SCAN_FREQ = 1000,
  parameter int DIGITS    = 8,
  parameter int BRIGHT_W  = 4
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst_n,
  input  logic [4*DIGITS-1:0]   seg_val,
  input  logic [DIGITS-1:0]     seg_en,
  input  logic [DIGITS-1:0]     seg_dp,
  input  logic [BRIGHT_W-1:0]   bright,
  input  logic                  upd,
  output logic [7:0]            seg_val_out,
  output logic [DIGITS-1:0]     seg_sel_out,
  output logic                  frame_done
);

  localparam int c_PERIOD = CLK_FREQ / SCAN_FREQ;
  localparam int c_PW     = (c_PERIOD > 1) ? $clog2(c_PERIOD) : 1;
  localparam int c_IW     = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int c_PERW   = (c_PERIOD > 0) ? $clog2(c_PERIOD + 1) : 1;
  localparam int c_PROD_W = BRIGHT_W + 1 + c_PERW;

  generate
    if (DIGITS < 1 || DIGITS > 16 || c_PERIOD < (2 ** BRIGHT_W)) begin : g_bad_cfg
      $error("seg_scan_ctrl: illegal DIGITS / PERIOD / BRIGHT_W configuration");
    end
  endgenerate

  logic [c_PW-1:0]       r_presc;
  logic [c_IW-1:0]       r_idx;
  logic                  r_frame_done;
  logic [4*DIGITS-1:0]   r_shd_val, r_act_val;
  logic [DIGITS-1:0]     r_shd_en,  r_act_en;
  logic [DIGITS-1:0]     r_shd_dp,  r_act_dp;
  logic [BRIGHT_W-1:0]   r_shd_bright, r_act_bright;
  logic [7:0]            r_seg_val;
  logic [DIGITS-1:0]     r_seg_sel;

  logic                  w_tick, w_wrap;
  logic [3:0]            w_nib;
  logic                  w_en, w_dp, w_lz_blank;
  logic [7:0]            w_dec, w_seg_nxt;
  logic [DIGITS-1:0]     w_sel_nxt;
  logic [c_PROD_W-1:0]   w_thresh;

  assign w_tick = (r_presc == c_PW'(c_PERIOD - 1));
  assign w_wrap = w_tick && (r_idx == c_IW'(DIGITS - 1));

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_presc      <= '0;
      r_idx        <= '0;
      r_frame_done <= 1'b0;
      r_shd_val    <= '0;
      r_shd_en     <= '0;
      r_shd_dp     <= '0;
      r_shd_bright <= '0;
      r_act_val    <= '0;
      r_act_en     <= '0;
      r_act_dp     <= '0;
      r_act_bright <= '0;
      r_seg_val    <= 8'hFF;
      r_seg_sel    <= '1;
    end else begin
      r_presc <= w_tick ? '0 : r_presc + c_PW'(1);
      if (w_wrap)
        r_idx <= '0;
      else if (w_tick)
        r_idx <= r_idx + c_IW'(1);
      r_frame_done <= w_wrap;
      if (upd) begin
        r_shd_val    <= seg_val;
        r_shd_en     <= seg_en;
        r_shd_dp     <= seg_dp;
        r_shd_bright <= bright;
      end
      // Active bank takes the pre-edge shadow, so a coincident upd lands a frame later.
      if (w_wrap) begin
        r_act_val    <= r_shd_val;
        r_act_en     <= r_shd_en;
        r_act_dp     <= r_shd_dp;
        r_act_bright <= r_shd_bright;
      end
      r_seg_val <= w_seg_nxt;
      r_seg_sel <= w_sel_nxt;
    end
  end

  assign w_nib = r_act_val[{r_idx, 2'b00} +: 4];
  assign w_en  = r_act_en[r_idx];
  assign w_dp  = r_act_dp[r_idx];

`ifdef SEG_LZ_BLANK_EN
  // Bit k is set while every digit from the top down to k is a dp-less zero.
  logic [DIGITS:0] w_lz_run;
  assign w_lz_run[DIGITS] = 1'b1;
  assign w_lz_run[0]      = 1'b0;
  genvar k;
  generate
    for (k = 1; k < DIGITS; k++) begin : g_lz
      assign w_lz_run[k] = w_lz_run[k+1] & (r_act_val[4*k +: 4] == 4'h0) & ~r_act_dp[k];
    end
  endgenerate
  assign w_lz_blank = w_lz_run[r_idx];
`else
  assign w_lz_blank = 1'b0;
`endif

  always_comb begin
    w_dec = 8'hFF;
    case (w_nib)
      4'h0: w_dec = 8'hC0;
      4'h1: w_dec = 8'hF9;
      4'h2: w_dec = 8'hA4;
      4'h3: w_dec = 8'hB0;
      4'h4: w_dec = 8'h99;
      4'h5: w_dec = 8'h92;
      4'h6: w_dec = 8'h82;
      4'h7: w_dec = 8'hF8;
      4'h8: w_dec = 8'h80;
      4'h9: w_dec = 8'h90;
      4'hA: w_dec = 8'h88;
      4'hB: w_dec = 8'h83;
      4'hC: w_dec = 8'hA7;
      4'hD: w_dec = 8'hA1;
      4'hE: w_dec = 8'h84;
      4'hF: w_dec = 8'h8E;
      default: w_dec = 8'hFF;
    endcase
  end

  assign w_seg_nxt = (!w_en || w_lz_blank) ? 8'hFF : {~w_dp, w_dec[6:0]};

  // On-time threshold: ((bright+1)*PERIOD) >> BRIGHT_W at full product width.
  assign w_thresh = ((c_PROD_W'(r_act_bright) + c_PROD_W'(1)) * c_PROD_W'(c_PERIOD)) >> BRIGHT_W;

  always_comb begin
    w_sel_nxt = '1;
    if (c_PROD_W'(r_presc) < w_thresh)
      w_sel_nxt[r_idx] = 1'b0;
  end

  assign seg_val_out = r_seg_val;
  assign seg_sel_out = r_seg_sel;
  assign frame_done  = r_frame_done;

endmodule
`default_nettype wire

// File: tb/tb_seg_scan_ctrl.sv
`default_nettype none
// Frame-level scoreboard bench for seg_scan_ctrl (CLK_FREQ=1600, SCAN_FREQ=100 -> PERIOD=16).
module tb_seg_scan_ctrl;

  localparam int c_DIG   = 8;
  localparam int c_SLOT  = 16;
  localparam int c_FRAME = c_DIG * c_SLOT;
  localparam int c_NF    = 7;

  typedef struct packed {
    logic [31:0] val;
    logic [7:0]  en;
    logic [7:0]  dp;
    logic [3:0]  br;
  } cfg_t;

  typedef struct {
    logic [63:0] segs;
    int          thr;
  } frame_t;

  typedef struct {
    int   off;
    cfg_t c;
  } act_t;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n;
  logic [31:0] seg_val;
  logic [7:0]  seg_en;
  logic [7:0]  seg_dp;
  logic [3:0]  bright;
  logic        upd;
  logic [7:0]  seg_val_out;
  logic [7:0]  seg_sel_out;
  logic        frame_done;

  frame_t exp_q[$];
  int     n_checks = 0;
  int     n_errors = 0;
  logic   mon_go   = 1'b0;
  logic   mon_done = 1'b0;

  always #5 sys_clk = ~sys_clk;

  seg_scan_ctrl #(
    .CLK_FREQ (1600),
    .SCAN_FREQ(100),
    .DIGITS   (8),
    .BRIGHT_W (4)
  ) dut (
    .sys_clk    (sys_clk),
    .sys_rst_n  (sys_rst_n),
    .seg_val    (seg_val),
    .seg_en     (seg_en),
    .seg_dp     (seg_dp),
    .bright     (bright),
    .upd        (upd),
    .seg_val_out(seg_val_out),
    .seg_sel_out(seg_sel_out),
    .frame_done (frame_done)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic wait_fd(input string who);
    int n = 0;
    do begin
      @(negedge sys_clk);
      n++;
    end while (frame_done !== 1'b1 && n < 300);
    if (frame_done !== 1'b1) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s: frame_done not seen within %0d cycles", who, n);
    end
  endtask

  function automatic logic [7:0] glyph(input logic [3:0] n);
    case (n)
      4'h0: return 8'hC0;  4'h1: return 8'hF9;  4'h2: return 8'hA4;  4'h3: return 8'hB0;
      4'h4: return 8'h99;  4'h5: return 8'h92;  4'h6: return 8'h82;  4'h7: return 8'hF8;
      4'h8: return 8'h80;  4'h9: return 8'h90;  4'hA: return 8'h88;  4'hB: return 8'h83;
      4'hC: return 8'hA7;  4'hD: return 8'hA1;  4'hE: return 8'h84;  default: return 8'h8E;
    endcase
  endfunction

  function automatic frame_t model_frame(input cfg_t c);
    frame_t     r;
    logic [7:0] blank;
    logic [7:0] g;
    blank = '0;
`ifdef SEG_LZ_BLANK_EN
    begin
      logic lz;
      lz = 1'b1;
      for (int k = 7; k >= 1; k--) begin
        if (lz && c.val[4*k +: 4] == 4'h0 && !c.dp[k]) blank[k] = 1'b1;
        else lz = 1'b0;
      end
    end
`endif
    r.segs = '0;
    for (int k = 0; k < 8; k++) begin
      g = glyph(c.val[4*k +: 4]);
      if (!c.en[k] || blank[k]) r.segs[8*k +: 8] = 8'hFF;
      else                      r.segs[8*k +: 8] = {~c.dp[k], g[6:0]};
    end
    r.thr = ((int'(c.br) + 1) * 16) >> 4;
    return r;
  endfunction

  task automatic drive(input cfg_t c);
    seg_val = c.val;
    seg_en  = c.en;
    seg_dp  = c.dp;
    bright  = c.br;
  endtask

  task automatic scramble();
    seg_val = ~seg_val;
    seg_en  = ~seg_en;
    seg_dp  = ~seg_dp;
    bright  = ~bright;
  endtask

  // Monitor: one captured frame (128 samples) per popped expectation.
  initial begin : monitor
    logic [7:0] cap_seg [c_FRAME];
    logic [7:0] cap_sel [c_FRAME];
    logic       cap_fd  [c_FRAME];
    frame_t     e;
    logic [7:0] want;
    int         bad, base, fd_cnt;
    wait (mon_go);
    wait_fd("mon_sync");
    for (int f = 0; f < c_NF; f++) begin
      for (int j = 0; j < c_FRAME; j++) begin
        @(negedge sys_clk);
        cap_seg[j] = seg_val_out;
        cap_sel[j] = seg_sel_out;
        cap_fd[j]  = frame_done;
      end
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL frame%0d: no expectation queued", f);
        continue;
      end
      e = exp_q.pop_front();
      for (int d = 0; d < c_DIG; d++) begin
        base = d * c_SLOT;
        bad  = 0;
        for (int p = c_SLOT - 1; p >= 0; p--)
          if (cap_seg[base+p] !== e.segs[8*d +: 8]) bad = p;
        chk($sformatf("f%0d_seg_d%0d_p%0d", f, d, bad), cap_seg[base+bad], e.segs[8*d +: 8]);
        bad = 0;
        for (int p = c_SLOT - 1; p >= 0; p--) begin
          want = 8'hFF;
          if (p < e.thr) want[d] = 1'b0;
          if (cap_sel[base+p] !== want) bad = p;
        end
        want = 8'hFF;
        if (bad < e.thr) want[d] = 1'b0;
        chk($sformatf("f%0d_sel_d%0d_p%0d", f, d, bad), cap_sel[base+bad], want);
      end
      fd_cnt = 0;
      for (int j = 0; j < c_FRAME; j++) if (cap_fd[j] === 1'b1) fd_cnt++;
      chk($sformatf("f%0d_fd_count", f), fd_cnt, 1);
      chk($sformatf("f%0d_fd_last", f), cap_fd[c_FRAME-1], 1'b1);
    end
    mon_done = 1'b1;
  end

  // Stimulus
  initial begin : stim
    act_t   tbl [c_NF];
    cfg_t   m_shd, m_act, pend_cfg;
    logic   pend;
    frame_t fr;
    int     n, cnt, fdc;

    tbl[0].off = 10;  tbl[0].c = {32'h0123_4567, 8'hFF, 8'h00, 4'hF};
    tbl[1].off = 50;  tbl[1].c = {32'h0123_4567, 8'hFF, 8'h00, 4'h7};
    tbl[2].off = 127; tbl[2].c = {32'h0123_4567, 8'hFF, 8'h04, 4'h0};
    tbl[3].off = -1;  tbl[3].c = '0;
    tbl[4].off = 0;   tbl[4].c = {32'h0000_00A0, 8'hFF, 8'h00, 4'hF};
    tbl[5].off = 90;  tbl[5].c = {32'h89AB_CDEF, 8'h0F, 8'h81, 4'h3};
    tbl[6].off = -1;  tbl[6].c = '0;

    sys_rst_n = 1'b0;
    upd       = 1'b0;
    drive('0);
    m_shd     = '0;
    m_act     = '0;
    pend      = 1'b0;
    pend_cfg  = '0;

    repeat (3) @(negedge sys_clk);
    chk("rst_seg", seg_val_out, 8'hFF);
    chk("rst_sel", seg_sel_out, 8'hFF);
    chk("rst_fd",  frame_done,  1'b0);
    sys_rst_n = 1'b1;
    n = 0;
    do begin
      @(negedge sys_clk);
      n++;
    end while (frame_done !== 1'b1 && n < 300);
    chk("first_frame_len", n, c_FRAME);

    mon_go = 1'b1;
    for (int f = 0; f < c_NF; f++) begin
      wait_fd("stim_sync");
      if (pend) begin
        upd = 1'b0;
        scramble();
      end
      m_act = m_shd;
      if (pend) begin
        m_shd = pend_cfg;
        pend  = 1'b0;
      end
      fr = model_frame(m_act);
      exp_q.push_back(fr);
      if (tbl[f].off >= 0) begin
        repeat (tbl[f].off) @(negedge sys_clk);
        drive(tbl[f].c);
        upd = 1'b1;
        if (tbl[f].off == c_FRAME - 1) begin
          pend     = 1'b1;
          pend_cfg = tbl[f].c;
        end else begin
          @(negedge sys_clk);
          upd   = 1'b0;
          m_shd = tbl[f].c;
          scramble();
        end
      end
    end

    n = 0;
    while (!mon_done && n < 400) begin
      @(negedge sys_clk);
      n++;
    end
    chk("monitor_done", mon_done, 1'b1);

    // Reset in the middle of digit 0 of a live frame.
    wait_fd("post_sync");
    repeat (2) @(negedge sys_clk);
    fr = model_frame(m_shd);
    chk("pre_rst_seg", seg_val_out, fr.segs[7:0]);
    chk("pre_rst_sel", seg_sel_out, 8'hFE);
    #2 sys_rst_n = 1'b0;
    #1;
    chk("async_rst_seg", seg_val_out, 8'hFF);
    chk("async_rst_sel", seg_sel_out, 8'hFF);
    @(negedge sys_clk);
    chk("midscan_rst_seg", seg_val_out, 8'hFF);
    chk("midscan_rst_sel", seg_sel_out, 8'hFF);
    chk("midscan_rst_fd",  frame_done,  1'b0);
    repeat (2) @(negedge sys_clk);
    sys_rst_n = 1'b1;

    cnt = 0;
    fdc = 0;
    for (int j = 0; j < 300; j++) begin
      @(negedge sys_clk);
      if (seg_val_out !== 8'hFF) cnt++;
      if (frame_done === 1'b1) fdc++;
    end
    chk("blank_after_rst", cnt, 0);
    chk("fd_after_rst", fdc, 2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire

// File: doc/seg_scan_ctrl.md
SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 50_000_000, the sys_clk frequency in Hz.
REQ-002 SHALL have parameter SCAN_FREQ, default 1000, the digit-step rate in Hz.
REQ-003 SHALL have parameter DIGITS, default 8, the number of digits (legal range 1..16).
REQ-004 SHALL have parameter BRIGHT_W, default 4, the brightness control width.
REQ-005 SHALL have port sys_clk, input, 1 bit: the single clock.
REQ-006 SHALL have port sys_rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-007 SHALL have port seg_val, input, 4*DIGITS bits: hex nibbles; digit k uses [4k+3:4k].
REQ-008 SHALL have port seg_en, input, DIGITS bits: per-digit enable; 0 blanks the digit.
REQ-009 SHALL have port seg_dp, input, DIGITS bits: per-digit decimal point.
REQ-010 SHALL have port bright, input, BRIGHT_W bits: duty level; all-ones means fully on.
REQ-011 SHALL have port upd, input, 1 bit: strobe that captures seg_val, seg_en, seg_dp and bright into the shadow registers.
REQ-012 SHALL have port seg_val_out, output, 8 bits: active-low segments; bit7 is dp, bits 6:0 are g..a.
REQ-013 SHALL have port seg_sel_out, output, DIGITS bits: active-low digit select; bit k selects digit k.
REQ-014 SHALL have port frame_done, output, 1 bit: one-cycle pulse at each frame wrap.

Function
REQ-015 SHALL derive PERIOD = CLK_FREQ/SCAN_FREQ; a prescaler counts 0..PERIOD-1, and wrapping from PERIOD-1 to 0 constitutes a tick.
REQ-016 SHALL advance the digit index on each tick, from 0 up to DIGITS-1 and then wrap to 0.
REQ-017 SHALL assert frame_done for exactly one cycle on the tick at which the index wraps from DIGITS-1 to 0.
REQ-018 SHALL load the shadow registers on any cycle with upd=1; the last upd before a wrap wins.
REQ-019 SHALL copy shadow to active registers only on the wrap tick, so no frame ever mixes old and new data.
REQ-020 SHALL, when upd coincides with the wrap tick, transfer the pre-cycle shadow contents to active, and the newly captured values SHALL take effect at the next wrap.
REQ-021 SHALL decode nibbles 0..F to C0,F9,A4,B0,99,92,82,F8,80,90,88,83,A7,A1,84,8E, and SHALL force bit7 low when dp is set.
REQ-022 SHALL drive seg_val_out=8'hFF when the current digit is disabled.
REQ-023 SHALL hold seg_sel_out[index] low only while prescaler < ((bright+1)*PERIOD)>>BRIGHT_W; all other bits SHALL be high.
REQ-024 SHALL register both seg_val_out and seg_sel_out, with 1-cycle latency from a change in index or prescaler state.
REQ-025 SHALL compute the brightness product at full width with no truncation before the shift.
REQ-026 SHALL reject an illegal configuration at elaboration: DIGITS outside 1..16, or PERIOD < 2**BRIGHT_W.

Reset
REQ-027 SHALL, on sys_rst_n low, immediately and asynchronously (including mid-frame) set: prescaler=0, index=0, frame_done=0, seg_val_out=8'hFF, seg_sel_out=all ones, and shadow and active registers to 0 (all digits disabled, bright=0).
REQ-028 SHALL, after reset release, remain blank until an upd followed by a wrap occurs.

Configuration
REQ-029 SHALL, when macro SEG_LZ_BLANK_EN is defined, blank leading digits: scanning from index DIGITS-1 down to 1, every digit with a zero nibble and no dp is blanked until the first digit that is nonzero or has dp set; digit 0 is never blanked by this rule.
REQ-030 SHALL, when SEG_LZ_BLANK_EN is undefined, contain no leading-zero logic and show zero nibbles as C0.

Verification
(All scenarios use CLK_FREQ=1600, SCAN_FREQ=100, DIGITS=8, BRIGHT_W=4, so PERIOD=16.)
REQ-031 Reset asserted mid-scan -> next cycle shows seg_val_out=FF, seg_sel_out=FF, frame_done=0.
REQ-032 seg_val=32'h0123_4567, seg_en=FF, bright=F, upd pulse -> after the next wrap, index 0 shows seg_val_out=F8 and seg_sel_out=FE for 16 cycles; index 7 shows C0; frame_done pulses every 128 cycles.
REQ-033 bright=7 -> the active select is low for 8 of each 16-cycle slot and high for 8; bright=0 -> low for 1 of 16.
REQ-034 seg_dp=8'h04 with the REQ-032 data -> digit 2 outputs 8'h12; all other digits are unchanged.
REQ-035 upd with new data mid-frame, and separately on the wrap cycle -> outputs unchanged until the following wrap, then the new data appears.
REQ-036 SEG_LZ_BLANK_EN defined, seg_val=32'h0000_00A0, seg_en=FF -> digits 7..2 output FF, digit 1 outputs 88, digit 0 outputs C0; with the macro undefined -> digits 7..2 output C0.
